// File: rtl/noc_credit_ingress_buffer.sv
// Credit-return ingress FIFO for the receiving end of a credit-based NoC link.
// Optional overflow monitor enabled by defining NOC_CREDIT_OVF_CHECK_EN.
module noc_credit_ingress_buffer #(
    parameter int FLIT_WIDTH = 64,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [FLIT_WIDTH-1:0]        flit_in,
    input  logic                         valid_in,
    output logic [FLIT_WIDTH-1:0]        flit_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic                         credit_out,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [$clog2(DEPTH+1)-1:0]   peak_occupancy,
    output logic [CNT_W-1:0]             flits_in_count,
    output logic [CNT_W-1:0]             flits_out_count,
    output logic                         overflow,
    output logic [CNT_W-1:0]             drop_count
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths stay legal.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    logic [FLIT_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [OCC_W-1:0]      occ_r;
    logic [OCC_W-1:0]      peak_r;
    logic [OCC_W-1:0]      occ_nxt_s;
    logic                  valid_r;
    logic                  credit_r;
    logic [CNT_W-1:0]      in_cnt_r;
    logic [CNT_W-1:0]      out_cnt_r;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;

    // Handshake decode and next occupancy.
    always_comb begin
        full_s = (occ_r == OCC_W'(DEPTH));
        pop_s  = valid_r & ready_in;
        push_s = valid_in & (~full_s | pop_s);
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + OCC_W'(1);
            2'b01:   occ_nxt_s = occ_r - OCC_W'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // FIFO storage, pointers, status, credit and counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            occ_r     <= '0;
            peak_r    <= '0;
            valid_r   <= 1'b0;
            credit_r  <= 1'b0;
            in_cnt_r  <= '0;
            out_cnt_r <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= flit_in;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
                in_cnt_r        <= in_cnt_r + CNT_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r  <= next_ptr(rd_ptr_r);
                out_cnt_r <= out_cnt_r + CNT_W'(1);
            end
            if (occ_nxt_s > peak_r) begin
                peak_r <= occ_nxt_s;
            end
            occ_r    <= occ_nxt_s;
            valid_r  <= (occ_nxt_s != '0);
            credit_r <= pop_s;
        end
    end

    assign flit_out        = mem_r[rd_ptr_r];
    assign valid_out       = valid_r;
    assign credit_out      = credit_r;
    assign occupancy       = occ_r;
    assign peak_occupancy  = peak_r;
    assign flits_in_count  = in_cnt_r;
    assign flits_out_count = out_cnt_r;

`ifdef NOC_CREDIT_OVF_CHECK_EN
    logic             drop_s;
    logic             overflow_r;
    logic [CNT_W-1:0] drop_cnt_r;

    assign drop_s = valid_in & full_s & ~pop_s;

    // Sticky overflow flag and drop counter; the dropped flit never reaches storage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= drop_cnt_r + CNT_W'(1);
        end
    end

`ifndef SYNTHESIS
    // Flag every upstream credit-contract violation during simulation.
    always_ff @(posedge clk) begin
        if (reset_n && drop_s) begin
            $error("noc_credit_ingress_buffer: flit dropped, push while full");
        end
    end
`endif

    assign overflow   = overflow_r;
    assign drop_count = drop_cnt_r;
`else
    assign overflow   = 1'b0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_noc_credit_ingress_buffer.sv
// Self-checking bench for noc_credit_ingress_buffer: queue-based reference model,
// per-cycle compare, directed scenarios and a credit-limited random-ready stream.
module tb_noc_credit_ingress_buffer;

    localparam int FW    = 64;
    localparam int DEPTH = 2;
    localparam int CW    = 32;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic [FW-1:0] flit_in;
    logic          valid_in;
    logic [FW-1:0] flit_out;
    logic          valid_out;
    logic          ready_in;
    logic          credit_out;
    logic [OW-1:0] occupancy;
    logic [OW-1:0] peak_occupancy;
    logic [CW-1:0] flits_in_count;
    logic [CW-1:0] flits_out_count;
    logic          overflow;
    logic [CW-1:0] drop_count;

    noc_credit_ingress_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .flit_in(flit_in), .valid_in(valid_in),
        .flit_out(flit_out), .valid_out(valid_out), .ready_in(ready_in),
        .credit_out(credit_out), .occupancy(occupancy), .peak_occupancy(peak_occupancy),
        .flits_in_count(flits_in_count), .flits_out_count(flits_out_count),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored flits plus plain counters.
    logic [FW-1:0] m_q[$];
    int  m_in = 0, m_out = 0, m_drop = 0, m_peak = 0;
    bit  m_ovf = 0, m_credit = 0;
    bit  cmp_en = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_q.delete();
            m_in = 0; m_out = 0; m_drop = 0; m_peak = 0; m_ovf = 0; m_credit = 0;
        end else begin
            bit was_full, pop;
            was_full = (m_q.size() == DEPTH);
            pop      = (m_q.size() > 0) && ready_in;
            if (pop) begin
                void'(m_q.pop_front());
                m_out++;
            end
            if (valid_in && (!was_full || pop)) begin
                m_q.push_back(flit_in);
                m_in++;
            end else if (valid_in) begin
                m_drop++;
                m_ovf = 1;
            end
            m_credit = pop;
            if (m_q.size() > m_peak) m_peak = m_q.size();
        end
    end

    // Per-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid_out", valid_out, m_q.size() != 0);
            chk("occupancy", occupancy, m_q.size());
            chk("peak", peak_occupancy, m_peak);
            chk("credit_out", credit_out, m_credit);
            chk("in_count", flits_in_count, m_in);
            chk("out_count", flits_out_count, m_out);
            if (m_q.size() != 0) chk("flit_out", flit_out, m_q[0]);
`ifdef NOC_CREDIT_OVF_CHECK_EN
            chk("overflow", overflow, m_ovf);
            chk("drop_count", drop_count, m_drop);
`else
            chk("overflow", overflow, 1'b0);
            chk("drop_count", drop_count, 0);
`endif
        end
    end

    task automatic cyc(input logic v, input logic [FW-1:0] d, input logic r);
        valid_in = v; flit_in = d; ready_in = r;
        @(negedge clk);
    endtask

    int sent, credits, pulses, cycles;

    initial begin
        reset_n = 1'b0; valid_in = 1'b1; flit_in = '0; ready_in = 1'b0;
        cmp_en = 1;
        // Reset held two cycles with valid_in high.
        cyc(1'b1, 64'h0, 1'b0);
        cyc(1'b1, 64'h0, 1'b0);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_credit", credit_out, 1'b0);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_cnt", flits_in_count, 0);
        chk("rst_flit", flit_out, 64'h0);
        reset_n = 1'b1;

        // Fill then drain.
        cyc(1'b1, 64'hD000, 1'b0);
        cyc(1'b1, 64'hD001, 1'b0);
        chk("fill_occ", occupancy, 2);
        chk("fill_peak", peak_occupancy, 2);
        chk("fill_head", flit_out, 64'hD000);
        chk("fill_credit", credit_out, 1'b0);
        cyc(1'b0, 64'h0, 1'b1);
        chk("drain1_head", flit_out, 64'hD001);
        chk("drain1_credit", credit_out, 1'b1);
        cyc(1'b0, 64'h0, 1'b1);
        chk("drain2_credit", credit_out, 1'b1);
        chk("drain2_valid", valid_out, 1'b0);
        cyc(1'b0, 64'h0, 1'b0);
        chk("drain3_credit", credit_out, 1'b0);

        // Simultaneous push and pop at full.
        cyc(1'b1, 64'hD000, 1'b0);
        cyc(1'b1, 64'hD001, 1'b0);
        cyc(1'b1, 64'hD002, 1'b1);
        chk("pp_occ", occupancy, 2);
        chk("pp_head", flit_out, 64'hD001);
        chk("pp_ovf", overflow, 1'b0);
        cyc(1'b0, 64'h0, 1'b1);
        chk("pp_head2", flit_out, 64'hD002);
        cyc(1'b0, 64'h0, 1'b1);
        cyc(1'b0, 64'h0, 1'b0);

        // Push while full with no pop: flit discarded.
        cyc(1'b1, 64'hD010, 1'b0);
        cyc(1'b1, 64'hD011, 1'b0);
        cyc(1'b1, 64'hDEAD, 1'b0);
        chk("ovf_in_cnt", flits_in_count, 7);
        chk("ovf_occ", occupancy, 2);
`ifdef NOC_CREDIT_OVF_CHECK_EN
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drops", drop_count, 1);
`else
        chk("ovf_flag", overflow, 1'b0);
`endif
        chk("ovf_head", flit_out, 64'hD010);
        cyc(1'b0, 64'h0, 1'b1);
        chk("ovf_head2", flit_out, 64'hD011);
        cyc(1'b0, 64'h0, 1'b1);
        chk("ovf_empty", valid_out, 1'b0);
        cyc(1'b0, 64'h0, 1'b0);

        // Reset coinciding with a pop.
        cyc(1'b1, 64'hD020, 1'b0);
        reset_n = 1'b0;
        cyc(1'b0, 64'h0, 1'b1);
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_credit", credit_out, 1'b0);
        reset_n = 1'b1;

        // Stream from a 2-credit upstream with random consumer stalls.
        sent = 0; credits = DEPTH; pulses = 0; cycles = 0;
        valid_in = 1'b0; ready_in = 1'b0;
        while ((sent < 100 || pulses < 100) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            chk("credit_invariant", credits + occupancy + credit_out, DEPTH);
            if (credit_out) begin
                credits++;
                pulses++;
            end
            if (sent < 100 && credits > 0) begin
                valid_in = 1'b1;
                flit_in  = 64'h1000 + 64'(sent);
                sent++;
                credits--;
            end else begin
                valid_in = 1'b0;
            end
            ready_in = ($urandom % 2) == 1;
        end
        if (cycles >= 3000) begin
            errors++;
            $display("FAIL stream_timeout: got %0d pulses expected 100", pulses);
        end
        valid_in = 1'b0; ready_in = 1'b0;
        @(negedge clk);
        chk("stream_pulses", pulses, 100);
        chk("stream_in_cnt", flits_in_count, 100);
        chk("stream_out_cnt", flits_out_count, 100);
        chk("stream_credits", credits, DEPTH);
        chk("stream_ovf", overflow, 1'b0);

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_credit_ingress_buffer.md
# noc_credit_ingress_buffer

Downstream (receiving) end of the credit-based NoC link. It accepts flits from an upstream router egress that sends only while it holds credits, and stores them in a small FIFO. It presents the flits to a local consumer with a valid/ready handshake, and returns one credit pulse upstream for every flit the consumer drains. It sits between a `noc_router_enhanced` egress configured with `USE_CREDIT=1` and a terminal sink or the next hop's ingress. Its `DEPTH` equals the upstream `CREDIT_INIT`.

## Interface
Parameters:
- `FLIT_WIDTH`, 64, flit width in bits.
- `DEPTH`, 2, FIFO entries; must equal upstream `CREDIT_INIT`; legal range 1..16.
- `CNT_W`, 32, width of the flit counters.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `flit_in`  in  `FLIT_WIDTH`  flit from the upstream egress.
- `valid_in`  in  1  push request. There is no ready return; the credit contract guarantees space.
- `flit_out`  out  `FLIT_WIDTH`  FIFO head.
- `valid_out`  out  1  high when the FIFO is non-empty.
- `ready_in`  in  1  consumer accepts the head.
- `credit_out`  out  1  one-cycle credit pulse to upstream `credit_in_*`.
- `occupancy`  out  `$clog2(DEPTH+1)`  current entry count.
- `peak_occupancy`  out  `$clog2(DEPTH+1)`  maximum occupancy since reset.
- `flits_in_count`  out  `CNT_W`  accepted pushes.
- `flits_out_count`  out  `CNT_W`  completed pops.
- `overflow`  out  1  sticky; set on a push while full with no pop. Active only with the macro.
- `drop_count`  out  `CNT_W`  dropped flits. Active only with the macro.

## Operation
- push = `valid_in` and (not full, or pop). pop = `valid_out` and `ready_in`.
- FIFO:
  - Circular buffer with read and write pointers of `$clog2(DEPTH)` bits (minimum 1 bit).
  - Each pointer wraps from `DEPTH-1` to 0. Non-power-of-two `DEPTH` is legal.
  - The occupancy counter tracks full/empty; pointer comparison is not used.
- Simultaneous push and pop:
  - At full: the push is accepted and occupancy is unchanged.
  - At empty: the pop is impossible (`valid_out`=0), so the push proceeds alone.
- Credit return:
  - `credit_out` is a register loaded with pop each cycle.
  - Exactly one pulse per pop; back-to-back pops give a continuous high level.
- Overflow (push while full, no pop):
  - The flit is discarded.
  - Stored entries, pointers and `flits_in_count` are untouched.
- Counters wrap modulo 2^`CNT_W`.
- `peak_occupancy` updates to the next occupancy whenever that value exceeds the current peak.
- Invariant: credits returned = `flits_out_count`; upstream credit level + `occupancy` + an in-flight `credit_out` = `DEPTH`.

## Timing
- Reset (`reset_n`=0 at a rising edge) clears all outputs, pointers and counters to 0:
  - `valid_out`=0, `credit_out`=0, `flit_out`=0, `overflow`=0.
  - A pending credit is not issued.
  - Reset mid-operation discards stored flits. The upstream router must be reset in the same cycle.
- Push at edge N: `valid_out`=1 and `flit_out` = that flit in cycle N+1. Minimum flit latency is 1 cycle; there is no combinational bypass.
- Pop at edge N: `credit_out`=1 for cycle N+1. The new head appears in cycle N+1.
- `flit_out` is driven from storage at the read pointer, registered/stable while `valid_out`=1 and `ready_in`=0.
- Sustained throughput is 1 flit/cycle with `ready_in`=1, provided upstream round-trip credit latency ≤ `DEPTH`.

## Configuration
- `NOC_CREDIT_OVF_CHECK_EN` defined:
  - `overflow` and `drop_count` are live.
  - A simulation-only `$error` fires on each drop.
- Not defined:
  - `overflow` and `drop_count` are tied to 0 and their logic is absent.
  - An overflowing push is still discarded; FIFO state is never corrupted.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `valid_in`=1 -> `valid_out`=0, `credit_out`=0, `occupancy`=0, all counters 0.
- Fill and drain (`DEPTH`=2):
  - Push 0xD000 and 0xD001 with `ready_in`=0 -> `occupancy`=2, `peak_occupancy`=2, no `credit_out`.
  - Raise `ready_in` -> 0xD000 then 0xD001 out; `credit_out` high for 2 consecutive cycles, each one cycle after its pop.
- Full with simultaneous push/pop:
  - At `occupancy`=2, push 0xD002 while popping -> `occupancy` stays 2, `overflow`=0.
  - Output order is D001, D002.
- Overflow (macro on):
  - At full with `ready_in`=0, push 0xDEAD -> `overflow`=1, `drop_count`=1, `flits_in_count` unchanged.
  - Drain -> original two flits, no 0xDEAD.
  - Macro off -> `overflow`=0, same data.
- Reset mid-operation: with `occupancy`=1 and a pop in the same cycle as `reset_n`=0 -> next cycle `occupancy`=0 and `credit_out`=0.
- Stream:
  - Setup: 100 flits from a model upstream holding 2 credits; `ready_in` random 50%.
  - Result: 100 delivered in order; 100 credit pulses; `flits_in_count`=`flits_out_count`=100.
  - Upstream credit is never negative; `overflow`=0.
